// File: rtl/cpu_control_unit_if.sv
// Program-memory fetch port and ALU port of the accumulator CPU control unit.
// A fetch completes on a rising edge where instr_req and instr_valid are both high; instr_valid is ignored otherwise.
interface cpu_control_unit_if;
  logic       instr_req;
  logic [7:0] instr_addr;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_sel;
  logic [7:0] alu_z;
  logic       alu_cout;

  modport master (
    output instr_req, instr_addr, alu_a, alu_b, alu_sel,
    input  instr_data, instr_valid, alu_z, alu_cout
  );

  modport slave (
    input  instr_req, instr_addr, alu_a, alu_b, alu_sel,
    output instr_data, instr_valid, alu_z, alu_cout
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Control unit of an 8-bit accumulator CPU: fetches 1- or 2-byte instructions,
// drives an external ALU for one EXECUTE cycle and writes the result back to acc.
module cpu_control_unit (
  input  logic                      clk,
  input  logic                      rst_n,
  cpu_control_unit_if.master        bus,
  output logic [7:0]                acc,
  output logic                      carry_flag,
  output logic                      zero_flag,
  output logic                      halted,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    EXECUTE   = 2'd2,
    HALT      = 2'd3
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_ADD1 = 4'h6;
  localparam logic [3:0] OP_SUB1 = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [4:0] SEL_ADD    = 5'b00000;
  localparam logic [4:0] SEL_AND    = 5'b00001;
  localparam logic [4:0] SEL_PASS_A = 5'b00010;
  localparam logic [4:0] SEL_PASS_B = 5'b00011;
  localparam logic [4:0] SEL_SUB    = 5'b01100;
  localparam logic [4:0] SEL_INC    = 5'b10100;
  localparam logic [4:0] SEL_ADD1   = 5'b00100;
  localparam logic [4:0] SEL_SUB1   = 5'b01000;

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_LDI) ||
           (op == OP_SUB) || (op == OP_ADD1) || (op == OP_SUB1);
  endfunction

  function automatic logic [4:0] exec_sel(input logic [3:0] op);
    logic [4:0] sel;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_AND:  sel = SEL_AND;
      OP_LDI:  sel = SEL_PASS_B;
      OP_SUB:  sel = SEL_SUB;
      OP_INC:  sel = SEL_INC;
      OP_ADD1: sel = SEL_ADD1;
      OP_SUB1: sel = SEL_SUB1;
      default: sel = SEL_PASS_A;
    endcase
    return sel;
  endfunction

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] acc_q;
  logic [7:0] opnd_q;
  logic [3:0] op_q;
  logic       carry_q;
  logic       zero_q;
  logic       halted_q;
  logic       instr_req_q;
  logic [4:0] alu_sel_q;

  logic       fetch_done;
  logic [3:0] fetch_op;
  logic [7:0] pc_inc;

  assign fetch_done = instr_req_q && bus.instr_valid;
  assign fetch_op   = bus.instr_data[7:4];
  assign pc_inc     = pc_q + 8'd1;

  // instr_req and alu_sel are registered alongside the state so they change
  // on the same edge that enters the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_OP;
      pc_q        <= 8'h00;
      acc_q       <= 8'h00;
      opnd_q      <= 8'h00;
      op_q        <= OP_NOP;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      halted_q    <= 1'b0;
      instr_req_q <= 1'b1;
      alu_sel_q   <= SEL_PASS_A;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (fetch_done) begin
            pc_q <= pc_inc;
            op_q <= fetch_op;
            if (is_two_byte(fetch_op)) begin
              state_q <= FETCH_IMM;
            end else if (fetch_op == OP_INC) begin
              state_q     <= EXECUTE;
              alu_sel_q   <= SEL_INC;
              instr_req_q <= 1'b0;
            end else if (fetch_op == OP_HLT) begin
              state_q     <= HALT;
              instr_req_q <= 1'b0;
              halted_q    <= 1'b1;
            end
          end
        end
        FETCH_IMM: begin
          if (fetch_done) begin
            pc_q        <= pc_inc;
            opnd_q      <= bus.instr_data;
            state_q     <= EXECUTE;
            alu_sel_q   <= exec_sel(op_q);
            instr_req_q <= 1'b0;
          end
        end
        EXECUTE: begin
          acc_q  <= bus.alu_z;
          zero_q <= (bus.alu_z == 8'h00);
          // LDI is a pure load and keeps the carry from the previous arithmetic op.
          if (op_q == OP_AND) begin
            carry_q <= 1'b0;
          end else if (op_q != OP_LDI) begin
            carry_q <= bus.alu_cout;
          end
          alu_sel_q   <= SEL_PASS_A;
          instr_req_q <= 1'b1;
          state_q     <= FETCH_OP;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= FETCH_OP;
        end
      endcase
    end
  end

  assign bus.instr_req  = instr_req_q;
  assign bus.instr_addr = pc_q;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = opnd_q;
  assign bus.alu_sel    = alu_sel_q;

  assign acc         = acc_q;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed programs plus random instruction streams
// checked against an instruction-level model of the accumulator machine.
module tb_cpu_control_unit;

  logic       clk;
  logic       rst_n;
  logic       acc;
  logic [7:0] acc_w;
  logic       carry_w;
  logic       zero_w;
  logic       halted_w;
  logic [1:0] dbg_state_w;
  logic [8:0] alu_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .acc         (acc_w),
    .carry_flag  (carry_w),
    .zero_flag   (zero_w),
    .halted      (halted_w),
    .dbg_state_o (dbg_state_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- external ALU ----------------
  always_comb begin
    alu_t = 9'd0;
    case (bus.alu_sel)
      5'b00000: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      5'b00001: alu_t = {1'b0, bus.alu_a & bus.alu_b};
      5'b00011: alu_t = {1'b0, bus.alu_b};
      5'b01100: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      5'b10100: alu_t = {1'b0, bus.alu_a} + 9'd1;
      5'b00100: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'd1;
      5'b01000: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - 9'd1;
      default:  alu_t = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_z    = alu_t[7:0];
  assign bus.alu_cout = alu_t[8];

  // ---------------- reference model ----------------
  logic [7:0] m_pc, m_acc, m_opnd;
  logic       m_c, m_z, m_halted;
  logic [4:0] sel_tab [16];
  logic [18:0] exp_q[$];
  bit pending;

  initial begin
    for (int i = 0; i < 16; i++) sel_tab[i] = 5'b00010;
    sel_tab[1] = 5'b00000; sel_tab[2] = 5'b00001; sel_tab[3] = 5'b00011;
    sel_tab[4] = 5'b01100; sel_tab[5] = 5'b10100; sel_tab[6] = 5'b00100;
    sel_tab[7] = 5'b01000;
  end

  task automatic model_reset();
    m_pc = 8'h00; m_acc = 8'h00; m_opnd = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_exec(input logic [3:0] op);
    int a, b, r;
    a = m_acc; b = m_opnd; r = a;
    case (op)
      4'h1: begin r = a + b;     m_c = (r > 255); end
      4'h2: begin r = a & b;     m_c = 1'b0;      end
      4'h3: begin r = b;                          end
      4'h4: begin r = a - b;     m_c = (r < 0);   end
      4'h5: begin r = a + 1;     m_c = (r > 255); end
      4'h6: begin r = a + b + 1; m_c = (r > 255); end
      4'h7: begin r = a - b - 1; m_c = (r < 0);   end
      default: ;
    endcase
    m_acc = r[7:0];
    m_z   = (r[7:0] == 8'h00);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_arch();
    logic [18:0] e;
    e = exp_q.pop_front();
    chk("arch_pc",     {24'd0, bus.instr_addr}, {24'd0, e[7:0]});
    chk("arch_acc",    {24'd0, acc_w},          {24'd0, e[15:8]});
    chk("arch_carry",  {31'd0, carry_w},        {31'd0, e[16]});
    chk("arch_zero",   {31'd0, zero_w},         {31'd0, e[17]});
    chk("arch_halted", {31'd0, halted_w},       {31'd0, e[18]});
    chk("arch_req",    {31'd0, bus.instr_req},  {31'd0, !e[18]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle_start();
    @(negedge clk);
    if (pending && exp_q.size() > 0) check_arch();
    pending = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'($urandom);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    pending = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_acc",    {24'd0, acc_w},          32'h00);
    chk("rst_pc",     {24'd0, bus.instr_addr}, 32'h00);
    chk("rst_carry",  {31'd0, carry_w},        32'h0);
    chk("rst_zero",   {31'd0, zero_w},         32'h0);
    chk("rst_halted", {31'd0, halted_w},       32'h0);
    chk("rst_sel",    {27'd0, bus.alu_sel},    32'h02);
    chk("rst_opnd",   {24'd0, bus.alu_b},      32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req", {31'd0, bus.instr_req}, 32'h1);
    model_reset();
  endtask

  task automatic do_reset();
    cycle_start();
    apply_reset();
  endtask

  task automatic fetch_byte(input logic [7:0] b, input int waits);
    for (int i = 0; i < waits; i++) begin
      cycle_start();
      chk("wait_req", {31'd0, bus.instr_req},  32'h1);
      chk("wait_pc",  {24'd0, bus.instr_addr}, {24'd0, m_pc});
      chk("wait_acc", {24'd0, acc_w},          {24'd0, m_acc});
    end
    cycle_start();
    chk("fetch_req", {31'd0, bus.instr_req},  32'h1);
    chk("fetch_pc",  {24'd0, bus.instr_addr}, {24'd0, m_pc});
    bus.instr_valid = 1'b1;
    bus.instr_data  = b;
    m_pc = m_pc + 8'd1;
  endtask

  task automatic exec_instr(input logic [7:0] op_b, input logic [7:0] imm, input int w1, input int w2);
    logic [3:0] op;
    bit two;
    op  = op_b[7:4];
    two = (op >= 4'h1) && (op <= 4'h7) && (op != 4'h5);
    fetch_byte(op_b, w1);
    if (two) begin
      fetch_byte(imm, w2);
      m_opnd = imm;
    end
    if (two || op == 4'h5) begin
      cycle_start();
      bus.instr_valid = 1'($urandom_range(0, 1));
      chk("exec_req", {31'd0, bus.instr_req}, 32'h0);
      chk("exec_sel", {27'd0, bus.alu_sel},   {27'd0, sel_tab[op]});
      chk("exec_a",   {24'd0, bus.alu_a},     {24'd0, m_acc});
      chk("exec_b",   {24'd0, bus.alu_b},     {24'd0, m_opnd});
      model_exec(op);
    end
    if (op == 4'hF) m_halted = 1'b1;
    exp_q.push_back({m_halted, m_z, m_c, m_acc, m_pc});
    pending = 1'b1;
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_start();
      bus.instr_valid = 1'($urandom_range(0, 1));
      chk("halt_req",    {31'd0, bus.instr_req},  32'h0);
      chk("halt_flag",   {31'd0, halted_w},       32'h1);
      chk("halt_pc",     {24'd0, bus.instr_addr}, {24'd0, m_pc});
      chk("halt_acc",    {24'd0, acc_w},          {24'd0, m_acc});
      chk("halt_carry",  {31'd0, carry_w},        {31'd0, m_c});
      chk("halt_zero",   {31'd0, zero_w},         {31'd0, m_z});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
    pending = 1'b0;
    model_reset();
    acc = 1'b0;

    // LDI 05; ADD FB wraps to zero with carry
    do_reset();
    c0 = cyc;
    exec_instr(8'h31, 8'h05, 0, 0);
    exec_instr(8'h11, 8'hFB, 0, 0);
    cycle_start();
    // one idle edge right after reset release, then six instruction cycles
    chk("r34_cycles", cyc - c0, 32'd7);
    chk("r34_acc",   {24'd0, acc_w},          32'h00);
    chk("r34_carry", {31'd0, carry_w},        32'h1);
    chk("r34_zero",  {31'd0, zero_w},         32'h1);
    chk("r34_pc",    {24'd0, bus.instr_addr}, 32'h04);

    // SUB borrow, then AND clears carry
    do_reset();
    exec_instr(8'h31, 8'h03, 0, 0);
    exec_instr(8'h41, 8'h05, 0, 0);
    cycle_start();
    chk("r35_acc",   {24'd0, acc_w},   32'hFE);
    chk("r35_carry", {31'd0, carry_w}, 32'h1);
    chk("r35_zero",  {31'd0, zero_w},  32'h0);
    exec_instr(8'h21, 8'h0F, 0, 0);
    cycle_start();
    chk("r35_and_acc",   {24'd0, acc_w},   32'h0E);
    chk("r35_and_carry", {31'd0, carry_w}, 32'h0);

    // INC
    exec_instr(8'h31, 8'h7F, 0, 0);
    exec_instr(8'h50, 8'h00, 0, 0);
    cycle_start();
    chk("r36_acc",   {24'd0, acc_w},   32'h80);
    chk("r36_carry", {31'd0, carry_w}, 32'h0);

    // wait states on the immediate byte
    exec_instr(8'h31, 8'h11, 0, 0);
    exec_instr(8'h1A, 8'h22, 1, 3);
    cycle_start();
    chk("r37_acc", {24'd0, acc_w}, 32'h33);

    // PC wrap through 256 NOPs, then halt
    do_reset();
    for (int i = 0; i < 255; i++)
      exec_instr({(i % 2 == 0) ? 4'h0 : 4'($urandom_range(8, 14)), 4'($urandom)}, 8'h00, 0, 0);
    cycle_start();
    chk("r38_pc_ff", {24'd0, bus.instr_addr}, 32'hFF);
    exec_instr(8'h0C, 8'h00, 0, 0);
    cycle_start();
    chk("r38_pc_00", {24'd0, bus.instr_addr}, 32'h00);
    exec_instr(8'hF0, 8'h00, 0, 0);
    halt_hold(20);

    // reset during EXECUTE of ADD abandons the writeback
    do_reset();
    exec_instr(8'h31, 8'hFF, 0, 0);
    exec_instr(8'h50, 8'h00, 0, 0);
    fetch_byte(8'h11, 0);
    fetch_byte(8'h03, 0);
    cycle_start();
    chk("r39_in_exec", {27'd0, bus.alu_sel}, 32'h00);
    apply_reset();

    // random instruction streams
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 250; i++)
        exec_instr({4'($urandom_range(0, 14)), 4'($urandom)}, 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      exec_instr(8'hF5, 8'h00, $urandom_range(0, 2), 0);
      halt_hold(8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
